// File: rtl/fft_output_collector.sv
// fft_output_collector
//   Ping-pong sink for the 64-point FFT core. Captures each 64-sample frame
//   arriving on In_Stream/Data_In into one of two banks. Re-presents buffered
//   frames, in capture order, on a valid/ready stream, so a stalling consumer
//   does not lose data while the core runs free.
//   A frame that starts while both banks are occupied is dropped whole.
//   A frame with a mid-frame gap in Data_In is aborted.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   In_Stream    32-bit sample {re[31:16], im[15:0]} from the core
//   Data_In      sample valid, 64 contiguous cycles per frame
//   Out_Data     buffered sample at Out_Index (0 while Out_Valid=0)
//   Out_Index    bin index 0..63
//   Out_Valid    Out_Data/Out_Index valid
//   Out_Ready    consumer accepts the beat
//   Out_Last     Out_Valid at bin 63
//   Frame_Drop   1-cycle pulse: a whole frame was dropped (no free bank)
//   Frame_Err    1-cycle pulse: a frame was aborted (Data_In gap)
//   Frame_Cnt    accepted-frame count, wraps at 256
module fft_output_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] In_Stream,
  input  logic        Data_In,
  output logic [31:0] Out_Data,
  output logic [5:0]  Out_Index,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic        Out_Last,
  output logic        Frame_Drop,
  output logic        Frame_Err,
  output logic [7:0]  Frame_Cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DISC} wstate_e;

  logic [1:0][63:0][31:0] bank_q;
  logic [1:0]             full_q, full_d;
  logic                   wb_q, rb_q;
  logic [5:0]             wr_ptr_q, rd_ptr_q;
  wstate_e                state_q;
  logic                   drop_q, err_q;
  logic [7:0]             cnt_q;

  logic hs, rd_done, wr_en, wr_done;

  // Read side is purely combinational from registered state.
  assign Out_Valid  = full_q[rb_q];
  assign Out_Index  = rd_ptr_q;
  assign Out_Data   = Out_Valid ? bank_q[rb_q][rd_ptr_q] : 32'd0;
  assign Out_Last   = Out_Valid && (rd_ptr_q == 6'd63);
  assign Frame_Drop = drop_q;
  assign Frame_Err  = err_q;
  assign Frame_Cnt  = cnt_q;

  assign hs      = Out_Valid && Out_Ready;
  assign rd_done = hs && (rd_ptr_q == 6'd63);
  // wr_ptr_q is always 0 in IDLE, so it doubles as the sample-0 address.
  assign wr_en   = Data_In && (((state_q == S_IDLE) && !full_q[wb_q]) || (state_q == S_CAPT));
  assign wr_done = (state_q == S_CAPT) && Data_In && (wr_ptr_q == 6'd63);

  // The writer only ever completes into a non-full bank and the reader only
  // releases a full one, so set and clear never target the same bank.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wb_q] = 1'b1;
    if (rd_done) full_d[rb_q] = 1'b0;
  end

  // Sample storage; contents are abandoned on reset and need no clear.
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[wb_q][wr_ptr_q] <= In_Stream;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
      full_q <= full_d;

      if (hs)      rd_ptr_q <= rd_ptr_q + 6'd1;
      if (rd_done) rb_q     <= ~rb_q;

      case (state_q)
        S_IDLE: begin
          if (Data_In) begin
            wr_ptr_q <= 6'd1;
            // Pre-edge full: a bank released this same edge is not yet free.
            state_q  <= full_q[wb_q] ? S_DISC : S_CAPT;
          end
        end
        S_CAPT, S_DISC: begin
          if (!Data_In) begin
            err_q    <= 1'b1;
            wr_ptr_q <= '0;
            state_q  <= S_IDLE;
          end else begin
            wr_ptr_q <= wr_ptr_q + 6'd1;  // wraps to 0 on the last sample
            if (wr_ptr_q == 6'd63) begin
              state_q <= S_IDLE;
              if (state_q == S_CAPT) begin
                wb_q  <= ~wb_q;
                cnt_q <= cnt_q + 8'd1;
              end else begin
                drop_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
